// File: rtl/csa_accum_ctrl_if.sv
// Operand/result handshake bundle for csa_accum_ctrl.
// The master side is the producer/consumer pair; the slave side is the sequencer.
interface csa_accum_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 7,
  parameter int CNT_W = 4
) ();
  logic             start;
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport master (
    output start, clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, result, busy, op_count
  );

  modport slave (
    input  start, clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, result, busy, op_count
  );
endinterface

// File: rtl/csa_accum_ctrl.sv
// Carry-save accumulation sequencer: folds NUM_OPS operands into a redundant
// (sum, carry) pair, then resolves them with one carry-propagate add.
module csa_accum_ctrl #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 8,
  parameter int ACC_W   = 7,
  parameter int CNT_W   = 4
) (
  input logic              clk,
  input logic              rst_n,
  csa_accum_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [ACC_W-1:0] sum_q, sum_d;
  logic [ACC_W-1:0] carry_q, carry_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] x;
  logic             hs;
  logic             last_op;

  function automatic logic [ACC_W-1:0] csa_sum(
    input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b, input logic [ACC_W-1:0] c
  );
    return a ^ b ^ c;
  endfunction

  // Majority bits move up one weight; the top carry falls off (result is mod 2^ACC_W).
  function automatic logic [ACC_W-1:0] csa_carry(
    input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b, input logic [ACC_W-1:0] c
  );
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  assign x       = ACC_W'(bus.in_data);
  assign hs      = bus.in_valid && (state_q == ACCUM);
  assign last_op = (cnt_q == CNT_W'(NUM_OPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start) state_d = ACCUM;
        ACCUM:   if (hs && last_op) state_d = RESOLVE;
        RESOLVE: state_d = DONE;
        DONE:    if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == ACCUM);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.result    = result_q;
    bus.op_count  = cnt_q;
  end

  // Datapath next values: clear wins over any handshake in the same cycle.
  always_comb begin
    sum_d    = sum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (bus.clear) begin
      sum_d   = '0;
      carry_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sum_d   = '0;
            carry_d = '0;
            cnt_d   = '0;
          end
        end
        ACCUM: begin
          if (hs) begin
            sum_d   = csa_sum(sum_q, carry_q, x);
            carry_d = csa_carry(sum_q, carry_q, x);
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        RESOLVE: result_d = sum_q + carry_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q    <= '0;
      carry_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule
